// File: rtl/kairos_loader_pkg.sv
// kairos_loader_pkg
// Shared types and constants for the Kairos pin-stream loader.
//   state_e     : top-level protocol phase
//   unload_ph_e : sub-phase of the result serialiser
//   half_sel_e  : low/high half selector for 16-bit <-> 32-bit conversion
//   CFG_*       : index of each configuration word in the config block
package kairos_loader_pkg;

  typedef enum logic [2:0] {
    CFG     = 3'd0,
    INSTR   = 3'd1,
    DATA    = 3'd2,
    START   = 3'd3,
    COMPUTE = 3'd4,
    UNLOAD  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    UN_READ  = 2'd0,
    UN_LATCH = 2'd1,
    UN_LO    = 2'd2,
    UN_HI    = 2'd3
  } unload_ph_e;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_sel_e;

  localparam int CFG_NINSTR  = 0;
  localparam int CFG_NIN     = 1;
  localparam int CFG_INBASE  = 2;
  localparam int CFG_NOUT    = 3;
  localparam int CFG_OUTBASE = 4;

  // Select one 16-bit half of a 32-bit word.
  function automatic logic [15:0] half_of(input logic [31:0] w, input half_sel_e sel);
    return (sel == HALF_HI) ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/kairos_half_packer.sv
// kairos_half_packer
// Assembles 32-bit words from consecutive 16-bit transfers, low half first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the toggle back to the low half (phase change)
//   in_fire    : a half-word transfer happens this cycle
//   in_half    : the transferred half-word
//   word_vld   : this transfer completes a word (high half)
//   word       : {in_half, held low half}, meaningful when word_vld
module kairos_half_packer
  import kairos_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_fire,
  input  logic [15:0] in_half,
  output logic        word_vld,
  output logic [31:0] word
);

  half_sel_e   sel_q, sel_d;
  logic [15:0] lo_q, lo_d;

  always_comb begin
    sel_d = sel_q;
    lo_d  = lo_q;
    if (in_fire) begin
      if (sel_q == HALF_LO) begin
        lo_d  = in_half;
        sel_d = HALF_HI;
      end else begin
        sel_d = HALF_LO;
      end
    end
    // clr wins so a new phase always begins on a low half
    if (clr) sel_d = HALF_LO;
  end

  assign word_vld = in_fire && (sel_q == HALF_HI);
  assign word     = {in_half, lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= HALF_LO;
      lo_q  <= '0;
    end else begin
      sel_q <= sel_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/kairos_stream_loader.sv
// kairos_stream_loader
// Receiving end of the Kairos 16-bit pin-stream protocol. Parses config
// words, the instruction program and repeated input batches, writes them
// into core memories, starts the core and streams results back out.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_vld/in_rdy/in_data       : inbound 16-bit stream
//   out_vld/out_rdy/out_data    : outbound 16-bit stream
//   instr_wen/addr/wdata        : instruction memory write port
//   mem_wen/ren/addr/wdata/rdata: data memory port (read data one cycle later)
//   core_start/core_done        : core handshake pulses
//   cfg_out                     : latched config words, word k at [16k+:16]
//   instr_csum                  : XOR of all instruction words written, only
//                                 present when KAIROS_LOADER_CHECKSUM_EN is defined
module kairos_stream_loader
  import kairos_loader_pkg::*;
#(
  parameter int NUM_CONFIGS = 5,
  parameter int IADDR_W     = 8,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [15:0]               in_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [15:0]               out_data,
  output logic                      instr_wen,
  output logic [IADDR_W-1:0]        instr_addr,
  output logic [31:0]               instr_wdata,
  output logic                      mem_wen,
  output logic                      mem_ren,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      core_start,
  input  logic                      core_done,
  output logic [NUM_CONFIGS*16-1:0] cfg_out
`ifdef KAIROS_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]               instr_csum
`endif
);

  localparam int CIDX_W = (NUM_CONFIGS > 1) ? $clog2(NUM_CONFIGS) : 1;

  state_e                    state_q, state_d;
  unload_ph_e                uph_q, uph_d;
  logic [CIDX_W-1:0]         cidx_q, cidx_d;
  logic [15:0]               idx_q, idx_d;
  logic [NUM_CONFIGS*16-1:0] cfg_q, cfg_d;
  logic [DATA_W-1:0]         hold_q, hold_d;
  logic                      rdy_q, rdy_d;
`ifdef KAIROS_LOADER_CHECKSUM_EN
  logic [31:0]               csum_q, csum_d;
`endif

  logic        in_fire;
  logic        load_fire;
  logic        word_vld;
  logic [31:0] word;
  logic [15:0] n_instr, n_in, n_out;
  logic [ADDR_W-1:0] addr_base;

  assign n_instr = cfg_q[CFG_NINSTR*16 +: 16];
  assign n_in    = cfg_q[CFG_NIN*16    +: 16];
  assign n_out   = cfg_q[CFG_NOUT*16   +: 16];

  // in_rdy comes straight from a flop so it never depends on in_vld
  assign in_fire   = in_vld && rdy_q;
  assign load_fire = in_fire && ((state_q == INSTR) || (state_q == DATA));

  kairos_half_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_d != state_q),
    .in_fire  (load_fire),
    .in_half  (in_data),
    .word_vld (word_vld),
    .word     (word)
  );

  always_comb begin
    state_d = state_q;
    uph_d   = uph_q;
    cidx_d  = cidx_q;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    hold_d  = hold_q;
`ifdef KAIROS_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      CFG: begin
        if (in_fire) begin
          for (int k = 0; k < NUM_CONFIGS; k++) begin
            if (cidx_q == CIDX_W'(k)) cfg_d[k*16 +: 16] = in_data;
          end
          if (cidx_q == CIDX_W'(NUM_CONFIGS-1)) begin
            cidx_d  = '0;
            idx_d   = '0;
            state_d = INSTR;
          end else begin
            cidx_d = cidx_q + CIDX_W'(1);
          end
        end
      end
      INSTR: begin
        if (word_vld) begin
`ifdef KAIROS_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ word;
`endif
          if (idx_q == n_instr) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      DATA: begin
        if (word_vld) begin
          if (idx_q == n_in) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      START: state_d = COMPUTE;
      COMPUTE: begin
        if (core_done) begin
          idx_d   = '0;
          uph_d   = UN_READ;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        case (uph_q)
          UN_READ:  uph_d = UN_LATCH;
          UN_LATCH: begin
            hold_d = mem_rdata;
            uph_d  = UN_LO;
          end
          UN_LO: if (out_rdy) uph_d = UN_HI;
          UN_HI: begin
            if (out_rdy) begin
              uph_d = UN_READ;
              if (idx_q == n_out) begin
                idx_d   = '0;
                state_d = DATA;
              end else begin
                idx_d = idx_q + 16'd1;
              end
            end
          end
          default: uph_d = UN_READ;
        endcase
      end
      default: state_d = CFG;
    endcase
    rdy_d = (state_d == CFG) || (state_d == INSTR) || (state_d == DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CFG;
      uph_q   <= UN_READ;
      cidx_q  <= '0;
      idx_q   <= '0;
      cfg_q   <= '0;
      hold_q  <= '0;
      rdy_q   <= 1'b0;
`ifdef KAIROS_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      uph_q   <= uph_d;
      cidx_q  <= cidx_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      hold_q  <= hold_d;
      rdy_q   <= rdy_d;
`ifdef KAIROS_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Read and write share one address: output base while unloading, else input base
  assign addr_base = (state_q == UNLOAD) ? cfg_q[CFG_OUTBASE*16 +: ADDR_W]
                                         : cfg_q[CFG_INBASE*16 +: ADDR_W];

  assign in_rdy      = rdy_q;
  assign instr_wen   = (state_q == INSTR) && word_vld;
  assign instr_addr  = idx_q[IADDR_W-1:0];
  assign instr_wdata = instr_wen ? word : '0;
  assign mem_wen     = (state_q == DATA) && word_vld;
  assign mem_wdata   = mem_wen ? word : '0;
  assign mem_addr    = addr_base + idx_q[ADDR_W-1:0];
  assign mem_ren     = (state_q == UNLOAD) && (uph_q == UN_READ);
  assign out_vld     = (state_q == UNLOAD) && ((uph_q == UN_LO) || (uph_q == UN_HI));
  assign out_data    = out_vld ? half_of(hold_q, (uph_q == UN_HI) ? HALF_HI : HALF_LO) : '0;
  assign core_start  = (state_q == START);
  assign cfg_out     = cfg_q;
`ifdef KAIROS_LOADER_CHECKSUM_EN
  assign instr_csum  = csum_q;
`endif

endmodule

// File: tb/tb_kairos_stream_loader.sv
module tb_kairos_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [15:0] in_data = 16'h0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [15:0] out_data;
  logic        instr_wen;
  logic [7:0]  instr_addr;
  logic [31:0] instr_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [79:0] cfg_out;
`ifdef KAIROS_LOADER_CHECKSUM_EN
  logic [31:0] instr_csum;
`endif

  kairos_stream_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .instr_wen(instr_wen), .instr_addr(instr_addr), .instr_wdata(instr_wdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_start(core_start), .core_done(core_done),
    .cfg_out(cfg_out)
`ifdef KAIROS_LOADER_CHECKSUM_EN
    , .instr_csum(instr_csum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Data memory: DUT-written words override bench preloads.
  logic [31:0] dut_mem [4096];
  bit          dut_wr  [4096];
  logic [31:0] pre_mem [4096];
  logic [31:0] exp_mem [4096];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen) begin
      dut_mem[mem_addr] <= mem_wdata;
      dut_wr[mem_addr]  <= 1'b1;
    end
    if (mem_ren) mem_rdata <= dut_wr[mem_addr] ? dut_mem[mem_addr] : pre_mem[mem_addr];
  end

  // Event logs
  int          iw_addr[$];
  logic [31:0] iw_data[$];
  int          mw_addr[$];
  logic [31:0] mw_data[$];
  int          mw_cyc[$];
  int          st_cyc[$];
  logic [15:0] oq[$];

  always @(negedge clk) begin
    if (instr_wen) begin iw_addr.push_back(int'(instr_addr)); iw_data.push_back(instr_wdata); end
    if (mem_wen) begin mw_addr.push_back(int'(mem_addr)); mw_data.push_back(mem_wdata); mw_cyc.push_back(cyc); end
    if (core_start) st_cyc.push_back(cyc);
    if (out_vld && out_rdy) oq.push_back(out_data);
  end

  logic [15:0] cfg_v [5];
  logic [31:0] bw [24];

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_word(input logic [15:0] w, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = w;
    in_vld  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 500) begin @(negedge clk); n++; end
    total++;
    if (!in_rdy) begin
      bad++;
      $display("FAIL send_timeout in_rdy=%0b required=1", in_rdy);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_cfg();
    for (int k = 0; k < 5; k++) send_word(cfg_v[k], $urandom_range(0, 1));
  endtask

  task automatic send_batch(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_word(bw[i][15:0], $urandom_range(0, max_gap));
      send_word(bw[i][31:16], $urandom_range(0, max_gap));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_vld = 1'b1;
    in_data = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_rdy, out_vld, instr_wen, mem_wen, mem_ren, core_start} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000000", {in_rdy, out_vld, instr_wen, mem_wen, mem_ren, core_start});
    end
    total++;
    if (cfg_out !== 80'h0) begin bad++; $display("FAIL reset_cfg got=%h want=0", cfg_out); end
    total++;
    if ({out_data, mem_addr, instr_addr, instr_wdata, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_buses out=%h maddr=%h iaddr=%h iwd=%h mwd=%h want=0", out_data, mem_addr, instr_addr, instr_wdata, mem_wdata);
    end
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%b want=1", in_rdy); end
  endtask

  task automatic test_config();
    int ib, mb;
    cfg_v[0] = 16'd125; cfg_v[1] = 16'd23; cfg_v[2] = 16'h07d0; cfg_v[3] = 16'd23; cfg_v[4] = 16'h07e8;
    ib = iw_addr.size(); mb = mw_addr.size();
    send_cfg();
    @(negedge clk);
    total++;
    if (cfg_out !== {cfg_v[4], cfg_v[3], cfg_v[2], cfg_v[1], cfg_v[0]}) begin
      bad++;
      $display("FAIL cfg_load got=%h want=%h", cfg_out, {cfg_v[4], cfg_v[3], cfg_v[2], cfg_v[1], cfg_v[0]});
    end
    total++;
    if (iw_addr.size() != ib || mw_addr.size() != mb) begin
      bad++;
      $display("FAIL cfg_no_strobes instr=%0d mem=%0d want=0 0", iw_addr.size() - ib, mw_addr.size() - mb);
    end
    total++;
    if (in_rdy !== 1'b1) begin bad++; $display("FAIL cfg_rdy got=%b want=1", in_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_instr();
    logic [31:0] words [126];
    logic [31:0] x;
    int ib, mb;
    ib = iw_addr.size(); mb = mw_addr.size(); x = 32'h0;
    for (int i = 0; i < 126; i++) begin
      words[i] = (i == 0) ? 32'h12345678 : $urandom();
      x ^= words[i];
    end
    for (int i = 0; i < 126; i++) begin
      send_word(words[i][15:0], $urandom_range(0, 1));
      send_word(words[i][31:16], $urandom_range(0, 2));
    end
    @(posedge clk); #1;
    total++;
    if (iw_addr.size() != ib + 126) begin
      bad++;
      $display("FAIL instr_count got=%0d want=126", iw_addr.size() - ib);
    end else begin
      total++;
      if (iw_addr[ib] !== 0 || iw_data[ib] !== 32'h12345678) begin
        bad++;
        $display("FAIL instr_first addr=%0d data=%h want 0 12345678", iw_addr[ib], iw_data[ib]);
      end
      for (int i = 0; i < 126; i++) begin
        total++;
        if (iw_addr[ib+i] != i || iw_data[ib+i] !== words[i]) begin
          bad++;
          $display("FAIL instr_word%0d addr=%0d data=%h want %0d %h", i, iw_addr[ib+i], iw_data[ib+i], i, words[i]);
        end
      end
    end
    total++;
    if (mw_addr.size() != mb) begin bad++; $display("FAIL instr_no_memwr got=%0d want=0", mw_addr.size() - mb); end
`ifdef KAIROS_LOADER_CHECKSUM_EN
    total++;
    if (instr_csum !== x) begin bad++; $display("FAIL instr_csum got=%h want=%h", instr_csum, x); end
`endif
  endtask

  task automatic test_batch_backpressure();
    int mb, sb, ob, n;
    mb = mw_addr.size(); sb = st_cyc.size(); ob = oq.size();
    for (int j = 0; j < 24; j++) begin
      pre_mem[12'h7e8 + j] = (j == 0) ? 32'hAABBCCDD : $urandom();
      exp_mem[12'h7e8 + j] = pre_mem[12'h7e8 + j];
    end
    for (int i = 0; i < 24; i++) begin
      bw[i] = $urandom();
      exp_mem[(12'h7d0 + i) & 12'hfff] = bw[i];
    end
    out_rdy = 1'b0;
    send_batch(24, 1);
    @(posedge clk); #1;
    total++;
    if (mw_addr.size() != mb + 24) begin
      bad++;
      $display("FAIL batch_count got=%0d want=24", mw_addr.size() - mb);
    end else begin
      for (int i = 0; i < 24; i++) begin
        total++;
        if (mw_addr[mb+i] != ((12'h7d0 + i) & 12'hfff) || mw_data[mb+i] !== bw[i]) begin
          bad++;
          $display("FAIL batch_wr%0d addr=%h data=%h want %h %h", i, mw_addr[mb+i], mw_data[mb+i], 12'h7d0 + i, bw[i]);
        end
      end
    end
    total++;
    if (st_cyc.size() != sb + 1) begin
      bad++;
      $display("FAIL batch_start_count got=%0d want=1", st_cyc.size() - sb);
    end else if (mw_addr.size() > 0) begin
      total++;
      if (st_cyc[sb] != mw_cyc[mw_cyc.size()-1] + 1) begin
        bad++;
        $display("FAIL batch_start_timing got=%0d want=%0d", st_cyc[sb], mw_cyc[mw_cyc.size()-1] + 1);
      end
    end
    // Words offered while computing must be refused.
    in_vld = 1'b1; in_data = 16'h5A5A;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (in_rdy !== 1'b0) begin bad++; $display("FAIL compute_rdy got=%b want=0", in_rdy); end
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    total++;
    if (mw_addr.size() != mb + 24) begin bad++; $display("FAIL compute_no_wr got=%0d want=24", mw_addr.size() - mb); end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_vld && n < 20) begin @(negedge clk); n++; end
    total++;
    if (out_vld !== 1'b1 || out_data !== 16'hCCDD) begin
      bad++;
      $display("FAIL unload_first vld=%b data=%h want 1 ccdd", out_vld, out_data);
    end
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (out_vld !== 1'b1 || out_data !== 16'hCCDD) begin
        bad++;
        $display("FAIL unload_hold vld=%b data=%h want 1 ccdd", out_vld, out_data);
      end
    end
    @(posedge clk); #1; out_rdy = 1'b1;
    @(posedge clk); #1; out_rdy = 1'b0;
    @(negedge clk);
    total++;
    if (out_vld !== 1'b1 || out_data !== 16'hAABB) begin
      bad++;
      $display("FAIL unload_high vld=%b data=%h want 1 aabb", out_vld, out_data);
    end
    n = 0;
    while (oq.size() < ob + 48 && n < 2000) begin
      @(posedge clk); #1;
      out_rdy = 1'($urandom_range(0, 1));
      n++;
    end
    out_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (oq.size() != ob + 48) begin
      bad++;
      $display("FAIL unload_count got=%0d want=48", oq.size() - ob);
    end else begin
      for (int j = 0; j < 48; j++) begin
        logic [31:0] w;
        w = exp_mem[(12'h7e8 + j/2) & 12'hfff];
        total++;
        if (oq[ob+j] !== ((j % 2) ? w[31:16] : w[15:0])) begin
          bad++;
          $display("FAIL unload_half%0d got=%h want=%h", j, oq[ob+j], (j % 2) ? w[31:16] : w[15:0]);
        end
      end
    end
    total++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      bad++;
      $display("FAIL unload_return rdy=%b vld=%b want 1 0", in_rdy, out_vld);
    end
  endtask

  task automatic test_back_to_back();
    int mb, sb, ob, sb0, ob0, n;
    sb0 = st_cyc.size(); ob0 = oq.size();
    // Spurious core_done while loading data
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || mem_ren !== 1'b0) begin
      bad++;
      $display("FAIL spurious_done vld=%b rdy=%b ren=%b want 0 1 0", out_vld, in_rdy, mem_ren);
    end
    for (int b = 0; b < 5; b++) begin
      mb = mw_addr.size(); sb = st_cyc.size(); ob = oq.size();
      for (int j = 0; j < 24; j++) begin
        pre_mem[12'h7e8 + j] = $urandom();
        exp_mem[12'h7e8 + j] = pre_mem[12'h7e8 + j];
      end
      for (int i = 0; i < 24; i++) begin
        bw[i] = $urandom();
        exp_mem[(12'h7d0 + i) & 12'hfff] = bw[i];
      end
      send_batch(24, 2);
      n = 0;
      while (st_cyc.size() == sb && n < 50) begin @(posedge clk); #1; n++; end
      total++;
      if (st_cyc.size() != sb + 1) begin
        bad++;
        $display("FAIL b2b_start%0d got=%0d want=1", b, st_cyc.size() - sb);
      end
      total++;
      if (mw_addr.size() != mb + 24 || mw_addr[mb] != 12'h7d0 || mw_data[mw_data.size()-1] !== bw[23]) begin
        bad++;
        $display("FAIL b2b_writes%0d n=%0d first=%h want 24 7d0", b, mw_addr.size() - mb, mw_addr[mb]);
      end
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
      n = 0;
      while (oq.size() < ob + 48 && n < 2000) begin
        @(posedge clk); #1;
        out_rdy = 1'($urandom_range(0, 3) != 0);
        n++;
      end
      out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (oq.size() != ob + 48) begin
        bad++;
        $display("FAIL b2b_out_count%0d got=%0d want=48", b, oq.size() - ob);
      end else begin
        int errs;
        errs = 0;
        for (int j = 0; j < 48; j++) begin
          logic [31:0] w;
          w = exp_mem[(12'h7e8 + j/2) & 12'hfff];
          if (oq[ob+j] !== ((j % 2) ? w[31:16] : w[15:0])) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL b2b_out_data%0d wrong_halves=%0d want=0", b, errs); end
      end
    end
    total++;
    if (st_cyc.size() - sb0 != 5 || oq.size() - ob0 != 240) begin
      bad++;
      $display("FAIL b2b_totals starts=%0d halves=%0d want 5 240", st_cyc.size() - sb0, oq.size() - ob0);
    end
  endtask

  task automatic test_reset_mid_instr();
    int ib, mb, ob, n;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_v[0] = 16'd3; cfg_v[1] = 16'd1; cfg_v[2] = 16'h0fff; cfg_v[3] = 16'd1; cfg_v[4] = 16'h07e8;
    send_cfg();
    send_word(16'hDEAD, 0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_rdy, out_vld, instr_wen, mem_wen, mem_ren, core_start} !== 6'b0 || cfg_out !== 80'h0) begin
      bad++;
      $display("FAIL midreset_outputs strobes=%b cfg=%h want 0 0", {in_rdy, out_vld, instr_wen, mem_wen, mem_ren, core_start}, cfg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cfg_v[4] = 16'h07f0;
    send_cfg();
    @(negedge clk);
    total++;
    if (cfg_out !== {cfg_v[4], cfg_v[3], cfg_v[2], cfg_v[1], cfg_v[0]}) begin
      bad++;
      $display("FAIL midreset_cfg got=%h want=%h", cfg_out, {cfg_v[4], cfg_v[3], cfg_v[2], cfg_v[1], cfg_v[0]});
    end
    @(posedge clk); #1;
    ib = iw_addr.size();
    begin
      logic [31:0] iw [4];
      logic [31:0] x;
      x = 32'h0;
      for (int i = 0; i < 4; i++) begin
        iw[i] = (i == 0) ? 32'h22221111 : $urandom();
        x ^= iw[i];
        send_word(iw[i][15:0], 0);
        send_word(iw[i][31:16], 0);
      end
      @(posedge clk); #1;
      total++;
      if (iw_addr.size() != ib + 4) begin
        bad++;
        $display("FAIL midreset_instr_count got=%0d want=4", iw_addr.size() - ib);
      end else begin
        total++;
        if (iw_addr[ib] != 0 || iw_data[ib] !== 32'h22221111) begin
          bad++;
          $display("FAIL midreset_no_stale addr=%0d data=%h want 0 22221111", iw_addr[ib], iw_data[ib]);
        end
        total++;
        if (iw_addr[ib+3] != 3 || iw_data[ib+3] !== iw[3]) begin
          bad++;
          $display("FAIL midreset_last addr=%0d data=%h want 3 %h", iw_addr[ib+3], iw_data[ib+3], iw[3]);
        end
      end
`ifdef KAIROS_LOADER_CHECKSUM_EN
      total++;
      if (instr_csum !== x) begin bad++; $display("FAIL midreset_csum got=%h want=%h", instr_csum, x); end
`endif
    end
    // Batch at the top of the address space wraps to zero.
    mb = mw_addr.size(); ob = oq.size();
    for (int j = 0; j < 2; j++) begin
      pre_mem[12'h7f0 + j] = $urandom();
      exp_mem[12'h7f0 + j] = pre_mem[12'h7f0 + j];
    end
    bw[0] = $urandom(); bw[1] = $urandom();
    send_batch(2, 1);
    @(posedge clk); #1;
    total++;
    if (mw_addr.size() != mb + 2 || mw_addr[mb] != 12'hfff || mw_addr[mb+1] != 12'h000 ||
        mw_data[mb] !== bw[0] || mw_data[mb+1] !== bw[1]) begin
      bad++;
      $display("FAIL wrap_writes n=%0d a0=%h a1=%h want 2 fff 000", mw_addr.size() - mb, mw_addr[mb], mw_addr[mb+1]);
    end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    n = 0;
    while (oq.size() < ob + 4 && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (oq.size() != ob + 4 || oq[ob] !== exp_mem[12'h7f0][15:0] || oq[ob+1] !== exp_mem[12'h7f0][31:16] ||
        oq[ob+2] !== exp_mem[12'h7f1][15:0] || oq[ob+3] !== exp_mem[12'h7f1][31:16]) begin
      bad++;
      $display("FAIL wrap_unload n=%0d want 4 words %h %h", oq.size() - ob, exp_mem[12'h7f0], exp_mem[12'h7f1]);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_instr();
    test_batch_backpressure();
    test_back_to_back();
    test_reset_mid_instr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d limit=50000", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kairos_stream_loader.md
Name: kairos_stream_loader

Overview:
On-chip receiving end of the Kairos 16-bit pin-stream protocol; sits between the mprj_io pad interface and the accelerator core.
- Parses the inbound stream: configuration words, then the instruction program, then repeated input-data batches.
- Writes instructions and data into core memories.
- Kicks the core and streams results back out on the 16-bit output valid/ready channel.

Parameters:
NUM_CONFIGS, 5, number of 16-bit config words at stream start
IADDR_W, 8, instruction memory address width
ADDR_W, 12, data memory address width
DATA_W, 32, memory word width (transferred as two 16-bit halves)

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  reset, asynchronous, active-low
in_vld  input  1  inbound word valid
in_rdy  output  1  loader accepts inbound word
in_data  input  16  inbound word
out_vld  output  1  outbound half-word valid
out_rdy  input  1  host accepts outbound half-word
out_data  output  16  outbound half-word
instr_wen  output  1  instruction memory write strobe
instr_addr  output  IADDR_W  instruction write address
instr_wdata  output  32  instruction word
mem_wen  output  1  data memory write strobe
mem_ren  output  1  data memory read strobe, rdata valid next cycle
mem_addr  output  ADDR_W  data memory address (shared read/write)
mem_wdata  output  32  data write word
mem_rdata  input  32  data read word
core_start  output  1  one-cycle pulse: batch loaded
core_done  input  1  one-cycle pulse: core finished batch
cfg_out  output  NUM_CONFIGS*16  latched config words, word k at [16k+:16]

Behaviour:
- Reset: all outputs 0, state CFG, counters 0, cfg registers 0. Reset mid-operation aborts the current transfer; no partial write is issued after reset deassertion.
- A transfer occurs when in_vld && in_rdy on a rising clk edge. in_rdy = 1 in CFG, INSTR and DATA; 0 in START, COMPUTE and UNLOAD. in_rdy is registered-state-derived, not combinational on in_vld.
- Config map:
  - cfg0 = instruction count-1
  - cfg1 = batch word count-1
  - cfg2 = input base address
  - cfg3 = output word count-1
  - cfg4 = output base address
- CFG: word k stored to cfg[k]. After word NUM_CONFIGS-1 -> INSTR.
- INSTR: halves arrive low first. The low half is held; the high half forms {high,low}. In the same cycle as the high-half transfer, instr_wen=1, instr_addr=index, instr_wdata=word. Index starts at 0. After index==cfg0 is written -> DATA.
- DATA: same half assembly. mem_wen=1 at mem_addr=cfg2+idx (ADDR_W wrap, no saturation). After idx==cfg1 -> START.
- START: core_start=1 for exactly one cycle -> COMPUTE.
- COMPUTE: wait for core_done. A core_done outside COMPUTE is ignored.
- UNLOAD: for j=0..cfg3:
  - mem_ren=1, mem_addr=cfg4+j.
  - Next cycle, latch mem_rdata into a hold register.
  - Present the low half with out_vld=1; hold until out_rdy.
  - Then present the high half; hold until out_rdy.
  - Then issue the next read.
  - out_data and out_vld stay stable while out_vld && !out_rdy.
  - After the last high half -> DATA; the batch index resets and the next batch overwrites from cfg2.
- The loop continues indefinitely; only reset returns to CFG.
- Half-word toggle resets to low at every phase change.
- Words are only ever written whole, so no partial write can occur.

Optional Feature:
KAIROS_LOADER_CHECKSUM_EN:
- Defined: adds output port instr_csum (32), the running XOR of every instruction word written. It clears on reset and is stable from DATA entry onward.
- Undefined: the port and its logic are absent.

Decomposition:
- Package kairos_loader_pkg holds:
  - the state enum (CFG, INSTR, DATA, START, COMPUTE, UNLOAD)
  - config index constants CFG_NINSTR=0, CFG_NIN=1, CFG_INBASE=2, CFG_NOUT=3, CFG_OUTBASE=4
  - the half-word select type
- One sub-module, kairos_half_packer, handles 16-to-32 assembly with a low/high toggle and is shared by INSTR and DATA.
- Unload serialisation stays inline.

Test Plan:
- Config load: send {125,23,0x7d0,23,0x7e8} -> cfg_out matches; state enters INSTR after the 5th word; no memory strobes.
- Instruction load: 126 words, with word 0 sent as halves 0x5678 then 0x1234 -> instr_wen with addr 0, data 0x12345678; last write at addr 125, then DATA.
- Batch:
  - Load 24 words -> mem_wen at addresses 0x7d0..0x7e7.
  - core_start pulses once, one cycle after the final write.
  - in_rdy drops until unload completes.
- Unload with backpressure:
  - Preload mem[0x7e8]=0xAABBCCDD; pulse core_done; hold out_rdy low 3 cycles -> out_data holds 0xCCDD, then sends 0xAABB.
  - 48 half-words are sent in total, then the loader returns to DATA.
- Five back-to-back batches (120 words) -> five core_start pulses and 5x48 output halves. A spurious core_done in DATA is ignored.
- Assert rst_n low mid-INSTR after a low half -> all outputs 0 and state CFG. After release, a fresh config stream is accepted with no stale half used.
